// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus host arbiter and any other fabric
// arbiter that reuses the round-robin picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int TimeoutCntWidth = 8;

  // Index width for n items; never narrower than one bit so n=1 still has a signal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NrReq.
module bus_rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NrReq = 2,
  parameter int SelW  = sel_width(NrReq)
) (
  input  logic [NrReq-1:0] i_req,
  input  logic [SelW-1:0]  i_rr,
  output logic [SelW-1:0]  o_winner,
  output logic             o_any_req
);

  int              w_idx;
  logic [SelW-1:0] w_pos;

  // Scan farthest-first so the request closest to the pointer is written last and wins.
  always_comb begin
    o_winner  = '0;
    o_any_req = |i_req;
    w_idx     = 0;
    w_pos     = '0;
    for (int i = NrReq - 1; i >= 0; i--) begin
      w_idx = int'(i_rr) + i;
      if (w_idx >= NrReq) begin
        w_idx = w_idx - NrReq;
      end
      w_pos = SelW'(w_idx);
      if (i_req[w_pos]) begin
        o_winner = w_pos;
      end
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one downstream bus port between NrHosts hosts,
// one outstanding transaction at a time, with a response timeout.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NrHosts       = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NrHosts-1:0]                      host_req_i,
  output logic [NrHosts-1:0]                      host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                      host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
  output logic [NrHosts-1:0]                      host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
  output logic [NrHosts-1:0]                      host_err_o,
  output logic                                    dev_req_o,
  input  logic                                    dev_gnt_i,
  output logic [AddressWidth-1:0]                 dev_addr_o,
  output logic                                    dev_we_o,
  output logic [DataWidth/8-1:0]                  dev_be_o,
  output logic [DataWidth-1:0]                    dev_wdata_o,
  input  logic                                    dev_rvalid_i,
  input  logic [DataWidth-1:0]                    dev_rdata_i,
  input  logic                                    dev_err_i,
  output logic [TimeoutCntWidth-1:0]              timeout_cnt_o
);

  localparam int SelW   = sel_width(NrHosts);
  localparam int TimerW = sel_width(TimeoutCycles + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);
  localparam logic [SelW-1:0]   SelLast   = SelW'(NrHosts - 1);

  arb_state_e                 r_state;
  logic [SelW-1:0]            r_rr;
  logic [SelW-1:0]            r_sel;
  logic [TimerW-1:0]          r_timer;
  logic [TimeoutCntWidth-1:0] r_timeout_cnt;

  logic [SelW-1:0] w_winner;
  logic [SelW-1:0] w_rr_next;
  logic            w_any_req;
  logic            w_timeout;

  bus_rr_pick #(
    .NrReq (NrHosts),
    .SelW  (SelW)
  ) u_pick (
    .i_req     (host_req_i),
    .i_rr      (r_rr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_timeout     = (r_timer == TimerLast);
  assign w_rr_next     = (r_sel == SelLast) ? '0 : r_sel + 1'b1;
  assign timeout_cnt_o = r_timeout_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_rr          <= '0;
      r_sel         <= '0;
      r_timer       <= '0;
      r_timeout_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_sel   <= w_winner;
            r_state <= REQ;
          end
        end
        REQ: begin
          // A withdrawn request abandons the slot without moving the pointer.
          if (!host_req_i[r_sel]) begin
            r_state <= IDLE;
          end else if (dev_gnt_i) begin
            r_timer <= '0;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_timer <= r_timer + 1'b1;
          if (dev_rvalid_i) begin
            r_rr    <= w_rr_next;
            r_state <= IDLE;
          end else if (w_timeout) begin
            if (r_timeout_cnt != '1) begin
              r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
            r_rr    <= w_rr_next;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Only the selected host ever sees grant/response traffic; a real response beats a timeout.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    dev_req_o     = 1'b0;
    dev_addr_o    = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_wdata_o   = '0;
    case (r_state)
      REQ: begin
        dev_req_o         = host_req_i[r_sel];
        dev_addr_o        = host_addr_i[r_sel];
        dev_we_o          = host_we_i[r_sel];
        dev_be_o          = host_be_i[r_sel];
        dev_wdata_o       = host_wdata_i[r_sel];
        host_gnt_o[r_sel] = dev_gnt_i & host_req_i[r_sel];
      end
      RESP: begin
        if (dev_rvalid_i) begin
          host_rvalid_o[r_sel] = 1'b1;
          host_rdata_o[r_sel]  = dev_rdata_i;
          host_err_o[r_sel]    = dev_err_i;
        end else if (w_timeout) begin
          host_rvalid_o[r_sel] = 1'b1;
          host_err_o[r_sel]    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Scoreboard bench for bus_host_arbiter: stimulus pushes expected grants and
// responses, an independent monitor pops and compares them as they appear.
module tb_bus_host_arbiter;

  localparam int NH = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  typedef struct {
    int            host;
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NH-1:0]          host_req_i;
  logic [NH-1:0]          host_gnt_o;
  logic [NH-1:0][AW-1:0]  host_addr_i;
  logic [NH-1:0]          host_we_i;
  logic [NH-1:0][DW/8-1:0] host_be_i;
  logic [NH-1:0][DW-1:0]  host_wdata_i;
  logic [NH-1:0]          host_rvalid_o;
  logic [NH-1:0][DW-1:0]  host_rdata_o;
  logic [NH-1:0]          host_err_o;
  logic                   dev_req_o;
  logic                   dev_gnt_i;
  logic [AW-1:0]          dev_addr_o;
  logic                   dev_we_o;
  logic [DW/8-1:0]        dev_be_o;
  logic [DW-1:0]          dev_wdata_o;
  logic                   dev_rvalid_i;
  logic [DW-1:0]          dev_rdata_i;
  logic                   dev_err_i;
  logic [7:0]             timeout_cnt_o;

  int    gntQ[$];
  resp_t respQ[$];
  int    assertCount = 0;
  int    failCount   = 0;
  int    cycleCount  = 0;
  int    lastGntCycle = -1;
  logic  spaceCheck = 1'b0;
  logic  autoResp;
  logic  fixedMode;
  logic [DW-1:0] fixedData;
  logic  respErr;

  bus_host_arbiter #(
    .NrHosts       (NH),
    .DataWidth     (DW),
    .AddressWidth  (AW),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .host_req_i    (host_req_i),
    .host_gnt_o    (host_gnt_o),
    .host_addr_i   (host_addr_i),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_wdata_i  (host_wdata_i),
    .host_rvalid_o (host_rvalid_o),
    .host_rdata_o  (host_rdata_o),
    .host_err_o    (host_err_o),
    .dev_req_o     (dev_req_o),
    .dev_gnt_i     (dev_gnt_i),
    .dev_addr_o    (dev_addr_o),
    .dev_we_o      (dev_we_o),
    .dev_be_o      (dev_be_o),
    .dev_wdata_o   (dev_wdata_o),
    .dev_rvalid_i  (dev_rvalid_i),
    .dev_rdata_i   (dev_rdata_i),
    .dev_err_i     (dev_err_i),
    .timeout_cnt_o (timeout_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // One clock; a zero-wait device answers in the cycle after it granted.
  task automatic tick();
    logic          g;
    logic [AW-1:0] a;
    #1;
    g = autoResp & dev_req_o & dev_gnt_i;
    a = dev_addr_o;
    @(posedge clk_i);
    @(negedge clk_i);
    dev_rvalid_i = g;
    dev_rdata_i  = g ? (fixedMode ? fixedData : (a ^ 32'hFFFF_0000)) : '0;
    dev_err_i    = g & respErr;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input logic [NH-1:0] req, input logic gnt, input logic auto);
    host_req_i = req;
    dev_gnt_i  = gnt;
    autoResp   = auto;
  endtask

  task automatic expectTxn(input int h, input logic [DW-1:0] d, input logic e);
    resp_t r;
    r.host = h;
    r.data = d;
    r.err  = e;
    gntQ.push_back(h);
    respQ.push_back(r);
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    applyStimulus('1, 1'b0, 1'b0);
    ticks(3);
    settle();
    checkOutput("rst_gnt", host_gnt_o, '0);
    checkOutput("rst_dev_req", dev_req_o, 1'b0);
    checkOutput("rst_rvalid", host_rvalid_o, '0);
    checkOutput("rst_timeout_cnt", timeout_cnt_o, 8'd0);
    rst_ni = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a grant or response is presented.
  initial begin
    resp_t         r;
    int            e;
    logic [NH-1:0] expGnt;
    logic [NH-1:0] expValid;
    logic [NH-1:0] expErr;
    logic [NH-1:0][DW-1:0] expData;
    forever begin
      @(negedge clk_i);
      #1;
      cycleCount++;
      if (!spaceCheck) lastGntCycle = -1;
      if (rst_ni === 1'b1) begin
        if (host_gnt_o !== '0) begin
          if (gntQ.size() == 0) begin
            checkOutput("gnt_unexpected", host_gnt_o, '0);
          end else begin
            e = gntQ.pop_front();
            expGnt = '0;
            expGnt[e] = 1'b1;
            checkOutput("gnt_onehot", host_gnt_o, expGnt);
            if (spaceCheck && lastGntCycle >= 0)
              checkOutput("gnt_spacing", cycleCount - lastGntCycle, 3);
            lastGntCycle = cycleCount;
          end
        end
        if (host_rvalid_o !== '0) begin
          if (respQ.size() == 0) begin
            checkOutput("rvalid_unexpected", host_rvalid_o, '0);
          end else begin
            r = respQ.pop_front();
            expValid = '0;
            expErr   = '0;
            expData  = '0;
            expValid[r.host] = 1'b1;
            expErr[r.host]   = r.err;
            expData[r.host]  = r.data;
            checkOutput("resp_rvalid", host_rvalid_o, expValid);
            checkOutput("resp_rdata", host_rdata_o, expData);
            checkOutput("resp_err", host_err_o, expErr);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want test end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni       = 1'b0;
    host_req_i   = '1;
    host_we_i    = '0;
    host_be_i    = '1;
    dev_gnt_i    = 1'b0;
    dev_rvalid_i = 1'b0;
    dev_rdata_i  = '0;
    dev_err_i    = 1'b0;
    autoResp     = 1'b0;
    fixedMode    = 1'b0;
    fixedData    = '0;
    respErr      = 1'b0;
    for (int h = 0; h < NH; h++) begin
      host_addr_i[h]  = AW'(32'h1000_0000 + h * 256);
      host_wdata_i[h] = DW'(32'h5A00_0000 + h);
    end

    // Reset, release, then hold off the grant for five REQ cycles.
    doReset();
    settle();
    checkOutput("release_idle", dev_req_o, 1'b0);
    tick();
    applyStimulus(3'b001, 1'b0, 1'b0);
    settle();
    checkOutput("release_req", dev_req_o, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) settle();
      checkOutput("bp_req", dev_req_o, 1'b1);
      checkOutput("bp_addr", dev_addr_o, 32'h1000_0000);
      checkOutput("bp_gnt", host_gnt_o, '0);
      tick();
    end
    respErr = 1'b0;
    applyStimulus(3'b001, 1'b1, 1'b1);
    expectTxn(0, 32'hEFFF_0000, 1'b0);
    tick();
    host_req_i = '0;
    tick();
    applyStimulus('0, 1'b0, 1'b0);
    tick();

    // Fairness with every host requesting and a zero-wait device.
    doReset();
    spaceCheck = 1'b1;
    applyStimulus(3'b111, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      expectTxn(0, 32'hEFFF_0000, 1'b0);
      expectTxn(1, 32'hEFFF_0100, 1'b0);
      expectTxn(2, 32'hEFFF_0200, 1'b0);
    end
    ticks(17);
    host_req_i = '0;
    tick();
    spaceCheck = 1'b0;
    applyStimulus('0, 1'b0, 1'b0);

    // Single host read with fixed data.
    host_addr_i[1] = 32'h1000_0040;
    fixedMode = 1'b1;
    fixedData = 32'hDEAD_BEEF;
    applyStimulus(3'b010, 1'b1, 1'b1);
    expectTxn(1, 32'hDEAD_BEEF, 1'b0);
    tick();
    settle();
    checkOutput("single_addr", dev_addr_o, 32'h1000_0040);
    checkOutput("single_we", dev_we_o, 1'b0);
    tick();
    host_req_i = '0;
    tick();
    fixedMode = 1'b0;
    applyStimulus('0, 1'b0, 1'b0);

    // Timeout on a silent device, then a late response that must be dropped.
    applyStimulus(3'b100, 1'b1, 1'b0);
    expectTxn(2, 32'h0, 1'b1);
    tick();
    tick();
    applyStimulus('0, 1'b0, 1'b0);
    ticks(2);
    settle();
    checkOutput("to_not_early", host_rvalid_o, '0);
    tick();
    settle();
    checkOutput("to_rvalid", host_rvalid_o, 3'b100);
    checkOutput("to_err", host_err_o, 3'b100);
    tick();
    settle();
    checkOutput("to_cnt", timeout_cnt_o, 8'd1);
    tick();
    dev_rvalid_i = 1'b1;
    dev_rdata_i  = 32'hCAFE_F00D;
    settle();
    checkOutput("late_rvalid_dropped", host_rvalid_o, '0);
    tick();

    // Abort before grant keeps the pointer; then a response on the timeout cycle.
    applyStimulus(3'b001, 1'b0, 1'b0);
    tick();
    settle();
    checkOutput("abort_req", dev_req_o, 1'b1);
    tick();
    host_req_i = '0;
    settle();
    checkOutput("abort_no_gnt", host_gnt_o, '0);
    tick();
    host_req_i = 3'b011;
    tick();
    applyStimulus(3'b011, 1'b1, 1'b0);
    expectTxn(0, 32'h1234_5678, 1'b0);
    settle();
    checkOutput("abort_rr_kept", dev_addr_o, 32'h1000_0000);
    tick();
    applyStimulus('0, 1'b0, 1'b0);
    ticks(3);
    dev_rvalid_i = 1'b1;
    dev_rdata_i  = 32'h1234_5678;
    dev_err_i    = 1'b0;
    tick();
    settle();
    checkOutput("tie_cnt", timeout_cnt_o, 8'd1);

    for (int i = 0; i < 20 && (gntQ.size() + respQ.size()) != 0; i++) tick();
    checkOutput("queues_drained", gntQ.size() + respQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
Round-robin arbiter that shares one downstream bus port between NrHosts Ibex-protocol hosts, replacing strict-priority host selection. It allows one outstanding transaction at a time, supports a variable downstream grant and response latency, and forces an error response on timeout. It sits between the cores/DMA hosts and the bus fabric's single host port.

Parameters:
NrHosts, 2, number of requesting hosts (>=1)
DataWidth, 32, data bus width in bits
AddressWidth, 32, address width in bits
TimeoutCycles, 255, maximum cycles waited for dev_rvalid_i after grant (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, synchronous, active-low
host_req_i  in  1 [NrHosts]  host request
host_gnt_o  out  1 [NrHosts]  host grant
host_addr_i  in  AddressWidth [NrHosts]  host address
host_we_i  in  1 [NrHosts]  write enable
host_be_i  in  DataWidth/8 [NrHosts]  byte enables
host_wdata_i  in  DataWidth [NrHosts]  write data
host_rvalid_o  out  1 [NrHosts]  response valid
host_rdata_o  out  DataWidth [NrHosts]  read data
host_err_o  out  1 [NrHosts]  response error
dev_req_o  out  1  downstream request
dev_gnt_i  in  1  downstream grant
dev_addr_o / dev_we_o / dev_be_o / dev_wdata_o  out  AddressWidth / 1 / DataWidth/8 / DataWidth  downstream request fields
dev_rvalid_i  in  1  downstream response valid
dev_rdata_i  in  DataWidth  downstream read data
dev_err_i  in  1  downstream error
timeout_cnt_o  out  8  saturating count of timed-out transactions

Behaviour:
- Reset (rst_ni low at a clk_i edge): state=IDLE, rr_q=0, sel_q=0, timer=0, timeout_cnt_o=0. All host_gnt_o, host_rvalid_o, host_err_o and dev_req_o are 0. host_rdata_o and dev_* fields are 0. Reset mid-transaction abandons the transaction with no response; a late dev_rvalid_i is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Winner = first host with host_req_i set, scanning indices rr_q, rr_q+1, … modulo NrHosts.
  - If there is a winner: sel_q<=winner, go to REQ.
  - No outputs are asserted in IDLE.
- REQ:
  - dev_req_o = host_req_i[sel_q].
  - dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o pass through combinationally from host sel_q.
  - host_gnt_o[sel_q] = dev_gnt_i & host_req_i[sel_q]; every other grant is 0.
  - On grant: timer<=0, go to RESP.
  - If host_req_i[sel_q] drops before grant: go to IDLE with no grant and rr_q unchanged.
- RESP:
  - dev_req_o=0, dev_* fields are 0.
  - timer increments each cycle.
  - If dev_rvalid_i=1: host_rvalid_o[sel_q]=1, host_rdata_o[sel_q]=dev_rdata_i, host_err_o[sel_q]=dev_err_i. Then rr_q<=(sel_q+1) mod NrHosts, go to IDLE.
  - Else if timer==TimeoutCycles-1: host_rvalid_o[sel_q]=1, host_err_o[sel_q]=1, host_rdata_o=0. Then timeout_cnt_o increments (saturates at 255), rr_q advances, go to IDLE.
  - dev_rvalid_i wins over timeout when both occur in the same cycle.
- Non-selected hosts always see rvalid/err/rdata = 0.
- dev_rvalid_i in IDLE or REQ (stray or late response) is ignored and never forwarded.
- Latency:
  - Request to earliest grant is 1 cycle.
  - A grant with zero-wait response completes 1 cycle later.
  - Minimum transaction is 3 cycles, including the IDLE arbitration cycle.
- Fairness: with all hosts requesting continuously, grants rotate 0,1,…,NrHosts-1,0.
- NrHosts=1: sel_q is fixed at 0 and the pointer logic degenerates; the selection width is max(1, $clog2(NrHosts)).

Decomposition:
- Package bus_arb_pkg:
  - arb_state_e enum {IDLE, REQ, RESP}
  - TimeoutCntWidth=8
  - function sel_width(n) returning max(1, $clog2(n))
- Sub-module bus_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, rr pointer.
  - Outputs: winner index, any_req.
  - Reusable by other fabric arbiters.
- The FSM, timer and muxing stay in bus_host_arbiter.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with host_req_i=all 1 → no grants, dev_req_o=0, timeout_cnt_o=0. Release → dev_req_o=1 for host 0 two cycles later.
- Single host: host1 reads addr 0x1000_0040; dev_gnt_i held 1; dev_rvalid_i one cycle after grant with rdata 0xDEADBEEF → host_rvalid_o[1]=1, host_rdata_o[1]=0xDEADBEEF, err=0, host0 outputs all 0.
- Round-robin: NrHosts=3, all hosts requesting continuously, zero-wait device → grant order 0,1,2,0,1,2, one grant every 3 cycles.
- Back-pressure: dev_gnt_i=0 for 5 cycles → dev_req_o and addr held stable, host_gnt_o=0. Grant on cycle 6 → exactly one host_gnt_o pulse.
- Timeout: TimeoutCycles=4, device never responds → host_rvalid_o=1, err=1, rdata=0 on the 4th RESP cycle; timeout_cnt_o=1. A dev_rvalid_i 2 cycles later is not forwarded.
- Abort and tie: host0 drops req in REQ before grant → IDLE, no grant, next winner still host0 if it re-requests. A response and the timeout in the same cycle → err=dev_err_i and timeout_cnt_o unchanged.
